instr_inv_scheduler: RTL and testbench
======================================

Name: instr_inv_scheduler

Overview:
- Buffers instruction-coherency invalidations raised by committed stores. Replays each one to the instruction cache and the branch predictor, which accept independently.
- Provides the drain handshake that the IFENCE path waits on before refetching.
- Sits between the store-commit/writeback side and the fetch-side invalidation ports. Instantiated only when INSTRUCTION_COHERENCY = 1.

Parameters:
- DEPTH, 4, queue entries. Power of 2, ≥2. Driven from INSTR_INV_QUEUE_DEPTH.
- LINE_W, 4, icache line size in words. Power of 2. Used for coalescing.
- INCLUDE_BP_INV, 1, when 0 the branch-predictor port is tied off and treated as always complete.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- inv_valid  in  1  store-side invalidation request
- inv_addr  in  30  word address [31:2] of the written location
- inv_ready  out  1  queue can accept this cycle
- icache_inv_valid  out  1  head entry offered to icache
- icache_inv_addr  out  30  head address
- icache_inv_ready  in  1  icache accepts
- bp_inv_valid  out  1  head entry offered to branch predictor
- bp_inv_addr  out  30  head address
- bp_inv_ready  in  1  predictor accepts
- fence_req  in  1  IFENCE drain request (single-cycle pulse)
- fence_ack  out  1  drain complete (single-cycle pulse)
- empty  out  1  no stored or in-flight invalidations

Behaviour:
- Reset (rst=0, async): queue empty; all done bits and fence_pending cleared. Outputs: inv_ready=1, icache_inv_valid=0, bp_inv_valid=0, fence_ack=0, empty=1. Addresses are don't-care. Any invalidation in flight is discarded; no partial handshake survives.
- Queue and push:
  - Circular FIFO of DEPTH entries with log2(DEPTH)+1-bit read/write pointers. The extra MSB distinguishes full from empty; pointers wrap naturally.
  - Push on inv_valid & inv_ready.
  - inv_ready = !full. It does not depend on a same-cycle pop, so there is no comb path from sink readies.
- Coalescing:
  - An accepted request is dropped (consumes nothing, still acknowledged) when all of the following hold: the queue is non-empty; the most recently written entry is still stored; that entry has not been offered-and-accepted by either sink; and inv_addr[29:log2(LINE_W)] equals that entry's line bits.
  - Otherwise the request is written at wptr.
- Head dispatch:
  - Per-head done bits ic_done and bp_done. bp_done is forced to 1 when INCLUDE_BP_INV=0.
  - icache_inv_valid = !empty_q & !ic_done; bp_inv_valid = !empty_q & !bp_done. Both carry mem[rptr].
  - Each sink handshake (valid&ready) sets its done bit. Sinks may accept in the same cycle or in any order.
  - Pop when (ic_done | ic_hs) & (bp_done | bp_hs). On pop, both done bits clear and the next head is offered the following cycle.
  - Valid is never withdrawn before its handshake, and the address is stable while valid.
- Latency: push at cycle N → both valids high at N+1 (registered storage). With both readies held at 1, throughput is one entry per cycle.
- Simultaneous push and pop: both take effect; occupancy is unchanged. A push into an empty queue in the same cycle as nothing to pop is legal. A pop of the last entry together with a push yields occupancy 1.
- Coalesce target popping the same cycle: coalescing is disallowed and the request is written normally.
- Fence:
  - fence_req sets fence_pending.
  - fence_ack pulses for one cycle on the first cycle where fence_pending=1 and the queue is empty after that cycle's updates (registered check). fence_pending then clears.
  - fence_req while the queue is already empty → fence_ack on the next cycle.
  - A fence_req arriving while pending is absorbed into the same ack.
  - Pushes accepted after fence_req also delay the ack. The issue side must stall stores during IFENCE.
- empty = (occupancy==0). It is a registered view.

Decomposition:
- Shared package (alongside the existing CPU configuration package):
  - inv_entry_t: packed struct holding the 30-bit addr.
  - Function inv_line_bits(addr, LINE_W) returning the coalescing tag.
  - Localparam MIN_INV_QUEUE_DEPTH = 2.
- One sub-module, instr_inv_fifo: pointers, storage, full/empty, last-entry tracking. The top holds done bits, coalescing, dispatch and fence logic.
- Elaboration assertion: DEPTH is a power of 2 and ≥2.

Test Plan:
- Reset release, push 0x0000_0100 with both readies=1 → both valids high next cycle with addr 0x0000_0100. Pop that cycle; empty=1 the cycle after.
- icache_inv_ready=1, bp_inv_ready=0 for 3 cycles then 1 → icache_inv_valid drops after 1 cycle, bp_inv_valid held 4 cycles. Single pop; no duplicate icache handshake.
- Both readies=0, push 4 distinct lines (0x10, 0x20, 0x30, 0x40; DEPTH=4) → inv_ready=0 after the 4th. Fifth push stalls. Raise readies → strict FIFO order, inv_ready=1 after the first pop.
- Readies=0, push 0x40 then 0x41 (same line, LINE_W=4) → one stored entry. Then push 0x44 → second entry.
- Readies=0, push 2 entries, fence_req pulse, release readies → fence_ack exactly one cycle after the second pop. fence_req on an empty queue → ack next cycle.
- Assert rst mid-dispatch with 3 entries queued and ic_done set → outputs at reset values immediately (async). After release, empty=1 and no stale valid.

Source files
------------

// File: rtl/instr_inv_scheduler_pkg.sv
// rtl/instr_inv_scheduler_pkg.sv - shared types and helpers for the instruction invalidation scheduler
package instr_inv_scheduler_pkg;

   localparam int ADDR_W              = 30;
   localparam int MIN_INV_QUEUE_DEPTH = 2;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
   } inv_entry_t;

   // Coalescing tag: the word address with the within-line word offset masked off
   function automatic logic [ADDR_W-1:0] inv_line_bits(input logic [ADDR_W-1:0] addr,
                                                       input int unsigned       line_w);
      logic [ADDR_W-1:0] mask;
      mask = ~(ADDR_W'(line_w) - ADDR_W'(1));
      return addr & mask;
   endfunction

endpackage

// File: rtl/instr_inv_scheduler_if.sv
// rtl/instr_inv_scheduler_if.sv - valid/ready invalidation channel carrying a word address
interface instr_inv_scheduler_if;
   import instr_inv_scheduler_pkg::*;

   logic              valid;
   logic [ADDR_W-1:0] addr;
   logic              ready;

   modport master (output valid, output addr, input ready);
   modport slave  (input valid, input addr, output ready);

endinterface

// File: rtl/instr_inv_fifo.sv
// rtl/instr_inv_fifo.sv - circular invalidation queue with head and last-written entry views
module instr_inv_fifo
   import instr_inv_scheduler_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  inv_entry_t push_entry,
   input  logic       pop,
   output inv_entry_t head,
   output inv_entry_t last,
   output logic       full,
   output logic       empty,
   output logic       single,
   output logic       empty_next
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wptr_q, rptr_q;
   logic [PW-1:0] occ, occ_next;
   logic [AW-1:0] last_idx;
   inv_entry_t    mem [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr_q[AW-1:0]] <= push_entry;
   end

   assign occ        = wptr_q - rptr_q;
   assign occ_next   = occ + PW'(push) - PW'(pop);
   assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty      = (wptr_q == rptr_q);
   assign single     = (occ == PW'(1));
   assign empty_next = (occ_next == '0);

   // While non-empty, the entry just behind wptr is the youngest one still stored
   assign last_idx   = wptr_q[AW-1:0] - AW'(1);
   assign head       = mem[rptr_q[AW-1:0]];
   assign last       = mem[last_idx];

endmodule

// File: rtl/instr_inv_scheduler.sv
// rtl/instr_inv_scheduler.sv - queues store-raised instruction invalidations and replays them to icache and predictor
module instr_inv_scheduler
   import instr_inv_scheduler_pkg::*;
#(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned LINE_W         = 4,
   parameter bit          INCLUDE_BP_INV = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   instr_inv_scheduler_if.slave  inv,
   instr_inv_scheduler_if.master icache_inv,
   instr_inv_scheduler_if.master bp_inv,
   input  logic                  fence_req,
   output logic                  fence_ack,
   output logic                  empty
);

   if (DEPTH < MIN_INV_QUEUE_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("instr_inv_scheduler: DEPTH must be a power of 2 and at least 2");
   end

   inv_entry_t push_entry, head, last;
   logic       full, empty_q, single, empty_next;
   logic       push_acc, coalesce, write, pop;
   logic       ic_done_q, bp_done_q, bp_done;
   logic       ic_hs, bp_hs, head_touched;
   logic       fence_pending_q, fence_ack_q, pending_now;

   instr_inv_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (write),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .last       (last),
      .full       (full),
      .empty      (empty_q),
      .single     (single),
      .empty_next (empty_next)
   );

   assign bp_done = INCLUDE_BP_INV ? bp_done_q : 1'b1;

   assign icache_inv.valid = !empty_q && !ic_done_q;
   assign icache_inv.addr  = head.addr;
   assign bp_inv.valid     = !empty_q && !bp_done;
   assign bp_inv.addr      = head.addr;
   assign inv.ready        = !full;

   assign ic_hs = icache_inv.valid && icache_inv.ready;
   assign bp_hs = bp_inv.valid && bp_inv.ready;
   assign pop   = !empty_q && (ic_done_q || ic_hs) && (bp_done || bp_hs);

   // A single stored entry is also the head; once any sink has taken it, merging would lose coverage
   assign head_touched = ic_done_q || ic_hs || bp_done_q || bp_hs || pop;

   assign push_entry = '{addr: inv.addr};
   assign push_acc   = inv.valid && !full;
   assign coalesce   = push_acc && !empty_q && !(single && head_touched) &&
                       (inv_line_bits(inv.addr, LINE_W) == inv_line_bits(last.addr, LINE_W));
   assign write      = push_acc && !coalesce;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ic_done_q <= 1'b0;
         bp_done_q <= 1'b0;
      end else if (pop) begin
         ic_done_q <= 1'b0;
         bp_done_q <= 1'b0;
      end else begin
         ic_done_q <= ic_done_q || ic_hs;
         bp_done_q <= bp_done_q || bp_hs;
      end
   end

   // The ack looks at occupancy after this cycle's push/pop, so it lands with the empty flag
   assign pending_now = fence_pending_q || fence_req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fence_pending_q <= 1'b0;
         fence_ack_q     <= 1'b0;
      end else begin
         fence_ack_q     <= pending_now && empty_next;
         fence_pending_q <= pending_now && !empty_next;
      end
   end

   assign fence_ack = fence_ack_q;
   assign empty     = empty_q;

endmodule

// File: tb/tb_instr_inv_scheduler.sv
// tb/tb_instr_inv_scheduler.sv - directed self-checking bench for instr_inv_scheduler
module tb_instr_inv_scheduler;

   logic clk;
   logic rst;
   logic fence_req;
   logic fence_ack;
   logic empty;
   int   vectors;
   int   miscompares;
   int   ic_hs_cnt;
   int   bp_hs_cnt;
   int   h0;

   instr_inv_scheduler_if inv_bus ();
   instr_inv_scheduler_if ic_bus ();
   instr_inv_scheduler_if bp_bus ();

   instr_inv_scheduler #(.DEPTH(4), .LINE_W(4), .INCLUDE_BP_INV(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .inv        (inv_bus),
      .icache_inv (ic_bus),
      .bp_inv     (bp_bus),
      .fence_req  (fence_req),
      .fence_ack  (fence_ack),
      .empty      (empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      ic_hs_cnt = 0;
      bp_hs_cnt = 0;
   end

   always @(posedge clk) begin
      if (ic_bus.valid === 1'b1 && ic_bus.ready === 1'b1) ic_hs_cnt <= ic_hs_cnt + 1;
      if (bp_bus.valid === 1'b1 && bp_bus.ready === 1'b1) bp_hs_cnt <= bp_hs_cnt + 1;
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic push_one(input logic [29:0] a);
      inv_bus.valid = 1'b1;
      inv_bus.addr  = a;
      @(negedge clk);
      inv_bus.valid = 1'b0;
   endtask

   task automatic set_ready(input logic ic, input logic bp);
      ic_bus.ready = ic;
      bp_bus.ready = bp;
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b0;
      fence_req     = 1'b0;
      inv_bus.valid = 1'b0;
      inv_bus.addr  = '0;
      set_ready(1'b0, 1'b0);

      repeat (3) cyc();
      check_vec("rst_inv_ready", 32'(inv_bus.ready), 32'd1);
      check_vec("rst_ic_valid", 32'(ic_bus.valid), 32'd0);
      check_vec("rst_bp_valid", 32'(bp_bus.valid), 32'd0);
      check_vec("rst_fence_ack", 32'(fence_ack), 32'd0);
      check_vec("rst_empty", 32'(empty), 32'd1);
      rst = 1'b1;
      cyc();

      // single entry through both sinks
      set_ready(1'b1, 1'b1);
      push_one(30'h100);
      check_vec("t1_ic_valid", 32'(ic_bus.valid), 32'd1);
      check_vec("t1_ic_addr", 32'(ic_bus.addr), 32'h100);
      check_vec("t1_bp_valid", 32'(bp_bus.valid), 32'd1);
      check_vec("t1_bp_addr", 32'(bp_bus.addr), 32'h100);
      cyc();
      check_vec("t1_empty", 32'(empty), 32'd1);
      check_vec("t1_ic_idle", 32'(ic_bus.valid), 32'd0);

      // predictor lags three cycles behind icache
      set_ready(1'b1, 1'b0);
      h0 = ic_hs_cnt;
      push_one(30'h200);
      check_vec("t2_a_ic", 32'(ic_bus.valid), 32'd1);
      check_vec("t2_a_bp", 32'(bp_bus.valid), 32'd1);
      cyc();
      check_vec("t2_b_ic", 32'(ic_bus.valid), 32'd0);
      check_vec("t2_b_bp", 32'(bp_bus.valid), 32'd1);
      cyc();
      check_vec("t2_c_ic", 32'(ic_bus.valid), 32'd0);
      check_vec("t2_c_bp", 32'(bp_bus.valid), 32'd1);
      cyc();
      check_vec("t2_d_bp", 32'(bp_bus.valid), 32'd1);
      check_vec("t2_d_bp_addr", 32'(bp_bus.addr), 32'h200);
      bp_bus.ready = 1'b1;
      cyc();
      check_vec("t2_e_bp", 32'(bp_bus.valid), 32'd0);
      check_vec("t2_e_empty", 32'(empty), 32'd1);
      check_vec("t2_ic_hs_once", 32'(ic_hs_cnt - h0), 32'd1);

      // fill to DEPTH, fifth push stalls, then strict FIFO drain
      set_ready(1'b0, 1'b0);
      push_one(30'h10);
      push_one(30'h20);
      push_one(30'h30);
      check_vec("t3_ready_3", 32'(inv_bus.ready), 32'd1);
      push_one(30'h40);
      check_vec("t3_full", 32'(inv_bus.ready), 32'd0);
      inv_bus.valid = 1'b1;
      inv_bus.addr  = 30'h50;
      cyc();
      check_vec("t3_stall", 32'(inv_bus.ready), 32'd0);
      check_vec("t3_head0", 32'(ic_bus.addr), 32'h10);
      set_ready(1'b1, 1'b1);
      cyc();
      check_vec("t3_ready_pop", 32'(inv_bus.ready), 32'd1);
      check_vec("t3_head1", 32'(ic_bus.addr), 32'h20);
      cyc();
      inv_bus.valid = 1'b0;
      check_vec("t3_head2", 32'(ic_bus.addr), 32'h30);
      cyc();
      check_vec("t3_head3", 32'(ic_bus.addr), 32'h40);
      cyc();
      check_vec("t3_head4", 32'(ic_bus.addr), 32'h50);
      check_vec("t3_head4_v", 32'(ic_bus.valid), 32'd1);
      cyc();
      check_vec("t3_empty", 32'(empty), 32'd1);

      // same-line coalescing
      set_ready(1'b0, 1'b0);
      push_one(30'h40);
      push_one(30'h41);
      push_one(30'h44);
      check_vec("t4_head", 32'(ic_bus.addr), 32'h40);
      set_ready(1'b1, 1'b1);
      h0 = ic_hs_cnt;
      cyc();
      check_vec("t4_second", 32'(ic_bus.addr), 32'h44);
      cyc();
      check_vec("t4_empty", 32'(empty), 32'd1);
      check_vec("t4_two_entries", 32'(ic_hs_cnt - h0), 32'd2);

      // coalesce target popping in the same cycle is written as a new entry
      push_one(30'h600);
      check_vec("t4_pop_head", 32'(ic_bus.addr), 32'h600);
      inv_bus.valid = 1'b1;
      inv_bus.addr  = 30'h601;
      cyc();
      inv_bus.valid = 1'b0;
      check_vec("t4_pop_new_v", 32'(ic_bus.valid), 32'd1);
      check_vec("t4_pop_new_a", 32'(ic_bus.addr), 32'h601);
      cyc();
      check_vec("t4_pop_empty", 32'(empty), 32'd1);

      // fence waits for the drain
      set_ready(1'b0, 1'b0);
      push_one(30'h80);
      push_one(30'h90);
      fence_req = 1'b1;
      cyc();
      fence_req = 1'b0;
      check_vec("t5_ack_wait0", 32'(fence_ack), 32'd0);
      cyc();
      check_vec("t5_ack_wait1", 32'(fence_ack), 32'd0);
      set_ready(1'b1, 1'b1);
      cyc();
      check_vec("t5_ack_wait2", 32'(fence_ack), 32'd0);
      check_vec("t5_head", 32'(ic_bus.addr), 32'h90);
      cyc();
      check_vec("t5_ack", 32'(fence_ack), 32'd1);
      check_vec("t5_empty", 32'(empty), 32'd1);
      cyc();
      check_vec("t5_ack_pulse", 32'(fence_ack), 32'd0);
      fence_req = 1'b1;
      cyc();
      fence_req = 1'b0;
      check_vec("t5_empty_ack", 32'(fence_ack), 32'd1);
      cyc();
      check_vec("t5_empty_ack_end", 32'(fence_ack), 32'd0);

      // asynchronous reset mid-dispatch
      set_ready(1'b1, 1'b0);
      push_one(30'h100);
      push_one(30'h200);
      push_one(30'h300);
      check_vec("t6_ic_done", 32'(ic_bus.valid), 32'd0);
      check_vec("t6_bp_wait", 32'(bp_bus.valid), 32'd1);
      check_vec("t6_bp_addr", 32'(bp_bus.addr), 32'h100);
      #2 rst = 1'b0;
      #1;
      check_vec("t6_rst_ic", 32'(ic_bus.valid), 32'd0);
      check_vec("t6_rst_bp", 32'(bp_bus.valid), 32'd0);
      check_vec("t6_rst_ready", 32'(inv_bus.ready), 32'd1);
      check_vec("t6_rst_empty", 32'(empty), 32'd1);
      check_vec("t6_rst_ack", 32'(fence_ack), 32'd0);
      cyc();
      rst = 1'b1;
      set_ready(1'b1, 1'b1);
      cyc();
      check_vec("t6_post_empty", 32'(empty), 32'd1);
      check_vec("t6_post_ic", 32'(ic_bus.valid), 32'd0);
      check_vec("t6_post_bp", 32'(bp_bus.valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
